// File: rtl/ring_seq_pkg.sv
// Shared definitions for the ring sequencer and the valve status block:
// direction encodings, a constant-foldable clog2, and one-hot to index.
package ring_seq_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Ceiling log2, usable in parameter defaults.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Bit position of a one-hot vector (OR of set-bit positions).
  function automatic logic [31:0] onehot_to_idx(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = r | 32'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Per-position dwell counter. tick is high while enabled and the count has
// reached the dwell value; the count restarts after every tick or clear.
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [DWELL_W-1:0] dwell,
  output logic               tick
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  // Compare is against the live dwell value, so a lowered dwell takes effect at once.
  assign tick = en && (cnt_q >= dwell);

  // Next count: clear has priority, then restart on tick, else count while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ring_sequencer.sv
// One-hot ring sequencer with programmable dwell, direction, direct load,
// binary index and advance/wrap pulses. Define RING_SEQ_ONEHOT_CHECK_EN to
// add the one-hot upset recovery and its err pulse output.
module ring_sequencer
  import ring_seq_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DWELL_W = 8,
  parameter int IDX_W   = clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               load,
  input  logic [IDX_W-1:0]   load_idx,
  output logic [WIDTH-1:0]   q,
  output logic [IDX_W-1:0]   idx,
  output logic               adv,
`ifdef RING_SEQ_ONEHOT_CHECK_EN
  output logic               wrap,
  output logic               err
`else
  output logic               wrap
`endif
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             adv_q, adv_d;
  logic             wrap_q, wrap_d;
  logic             load_ok;
  logic             recover;
  logic             tick;

  // Out-of-range load indices are treated as no load at all.
  assign load_ok = load && (int'(load_idx) < WIDTH);

`ifdef RING_SEQ_ONEHOT_CHECK_EN
  logic err_q;
  assign recover = !$onehot(q_q);
  assign err     = err_q;

  // err pulses on the edge that repairs a corrupted ring, even if a load wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= recover;
  end
`else
  assign recover = 1'b0;
`endif

  dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clr   (load_ok | recover),
    .dwell (dwell),
    .tick  (tick)
  );

  // Next ring state: load, then upset recovery, then a dwell-timed rotate.
  always_comb begin
    q_d    = q_q;
    idx_d  = idx_q;
    adv_d  = 1'b0;
    wrap_d = 1'b0;
    if (load_ok) begin
      q_d   = WIDTH'(1) << load_idx;
      idx_d = load_idx;
    end else if (recover) begin
      q_d   = WIDTH'(1);
      idx_d = '0;
    end else if (tick) begin
      adv_d = 1'b1;
      if (dir == DIR_UP) begin
        q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        wrap_d = q_q[WIDTH-1];
      end else begin
        q_d    = {q_q[0], q_q[WIDTH-1:1]};
        wrap_d = q_q[0];
      end
      idx_d = IDX_W'(onehot_to_idx(32'(q_d)));
    end
  end

  // Ring, index and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= WIDTH'(1);
      idx_q  <= '0;
      adv_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      idx_q  <= idx_d;
      adv_q  <= adv_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign idx  = idx_q;
  assign adv  = adv_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_ring_sequencer.sv
// Bench for ring_sequencer: a 4-position and a 6-position instance share
// control inputs; an integer position model predicts every cycle.
module tb_ring_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [7:0] dwell_a = 8'd0;
  logic [3:0] dwell_b = 4'd0;
  logic [1:0] lidx_a = 2'd0;
  logic [2:0] lidx_b = 3'd0;

  logic [3:0] q_a;
  logic [1:0] idx_a;
  logic       adv_a, wrap_a;
  logic [5:0] q_b;
  logic [2:0] idx_b;
  logic       adv_b, wrap_b;
`ifdef RING_SEQ_ONEHOT_CHECK_EN
  logic       err_a, err_b;
  bit         inj_a = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ring_sequencer #(.WIDTH(4), .DWELL_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .dwell(dwell_a),
    .load(load), .load_idx(lidx_a), .q(q_a), .idx(idx_a), .adv(adv_a),
`ifdef RING_SEQ_ONEHOT_CHECK_EN
    .wrap(wrap_a), .err(err_a)
`else
    .wrap(wrap_a)
`endif
  );

  ring_sequencer #(.WIDTH(6), .DWELL_W(4)) dut_b (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .dwell(dwell_b),
    .load(load), .load_idx(lidx_b), .q(q_b), .idx(idx_b), .adv(adv_b),
`ifdef RING_SEQ_ONEHOT_CHECK_EN
    .wrap(wrap_b), .err(err_b)
`else
    .wrap(wrap_b)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: active position as an integer, dwell count, last-edge pulses.
  typedef struct {
    int pos;
    int cnt;
    bit adv;
    bit wrap;
    bit err;
  } mstate_t;

  mstate_t ma, mb;

  function automatic mstate_t m_reset();
    mstate_t s;
    s.pos = 0; s.cnt = 0; s.adv = 0; s.wrap = 0; s.err = 0;
    return s;
  endfunction

  function automatic mstate_t m_step(mstate_t s, int w, bit e, bit d, int dw,
                                     bit ld, int li, bit upset);
    mstate_t n;
    n = s;
    n.adv = 0; n.wrap = 0; n.err = upset;
    if (ld && li < w) begin
      n.pos = li; n.cnt = 0;
    end else if (upset) begin
      n.pos = 0; n.cnt = 0;
    end else if (e) begin
      if (s.cnt >= dw) begin
        n.cnt = 0;
        n.adv = 1;
        if (!d) begin
          n.wrap = (s.pos == w - 1);
          n.pos  = (s.pos + 1) % w;
        end else begin
          n.wrap = (s.pos == 0);
          n.pos  = (s.pos + w - 1) % w;
        end
      end else begin
        n.cnt = s.cnt + 1;
      end
    end
    return n;
  endfunction

  // Advance the model on every edge, then compare shortly after the edge.
  always @(posedge clk or posedge rst) begin
    bit up;
    up = 1'b0;
`ifdef RING_SEQ_ONEHOT_CHECK_EN
    up = inj_a;
`endif
    if (rst) begin
      ma = m_reset();
      mb = m_reset();
    end else begin
      ma = m_step(ma, 4, en, dir, int'(dwell_a), load, int'(lidx_a), up);
      mb = m_step(mb, 6, en, dir, int'(dwell_b), load, int'(lidx_b), 1'b0);
    end
    #1;
    check("a_q",    int'(q_a),    1 << ma.pos);
    check("a_idx",  int'(idx_a),  ma.pos);
    check("a_adv",  int'(adv_a),  int'(ma.adv));
    check("a_wrap", int'(wrap_a), int'(ma.wrap));
    check("b_q",    int'(q_b),    1 << mb.pos);
    check("b_idx",  int'(idx_b),  mb.pos);
    check("b_adv",  int'(adv_b),  int'(mb.adv));
    check("b_wrap", int'(wrap_b), int'(mb.wrap));
`ifdef RING_SEQ_ONEHOT_CHECK_EN
    check("a_err",  int'(err_a),  int'(ma.err));
    check("b_err",  int'(err_b),  0);
`endif
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_q [4];
    logic       exp_w [4];
    int adv_cnt, wrap_cnt;
    exp_q = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_w = '{1'b0, 1'b0, 1'b0, 1'b1};

    // 1: reset then dwell=0 full lap
    tick(3);
    check("rst_q", int'(q_a), 'h1);
    check("rst_idx", int'(idx_a), 0);
    check("rst_adv", int'(adv_a), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("lap_q", int'(q_a), int'(exp_q[i]));
      check("lap_adv", int'(adv_a), 1);
      check("lap_wrap", int'(wrap_a), int'(exp_w[i]));
    end

    // 2: dwell=2, then freeze with en=0 mid-step
    dwell_a = 8'd2;
    tick(2);
    check("dw_hold_q", int'(q_a), 'h1);
    check("dw_hold_adv", int'(adv_a), 0);
    tick(1);
    check("dw_step_q", int'(q_a), 'h2);
    check("dw_step_adv", int'(adv_a), 1);
    tick(1);
    en = 1'b0;
    tick(5);
    check("frz_q", int'(q_a), 'h2);
    check("frz_adv", int'(adv_a), 0);
    en = 1'b1;
    tick(1);
    check("resume_q", int'(q_a), 'h2);
    tick(1);
    check("resume_step_q", int'(q_a), 'h4);
    check("resume_adv", int'(adv_a), 1);

    // 3: direction down across the boundary, then dir change mid-dwell
    load = 1'b1; lidx_a = 2'd0; lidx_b = 3'd0;
    tick(1);
    load = 1'b0;
    dwell_a = 8'd0; dir = 1'b1;
    tick(1);
    check("down_wrap_q", int'(q_a), 'h8);
    check("down_wrap", int'(wrap_a), 1);
    tick(1);
    check("down_q", int'(q_a), 'h4);
    check("down_nowrap", int'(wrap_a), 0);
    dwell_a = 8'd3;
    tick(1);
    dir = 1'b0;
    tick(2);
    check("dirchg_hold_q", int'(q_a), 'h4);
    tick(1);
    check("dirchg_q", int'(q_a), 'h8);
    check("dirchg_adv", int'(adv_a), 1);

    // 4: load mid-dwell, out-of-range load on the 6-wide ring, reset mid-dwell
    tick(1);
    load = 1'b1; lidx_a = 2'd2; lidx_b = 3'd6;
    tick(1);
    load = 1'b0;
    check("load_q", int'(q_a), 'h4);
    check("load_idx", int'(idx_a), 2);
    check("load_adv", int'(adv_a), 0);
    check("badload_adv", int'(adv_b), 1);
    tick(2);
    rst = 1'b1;
    #1;
    check("midrst_q", int'(q_a), 'h1);
    check("midrst_idx", int'(idx_a), 0);

    // 5: 6-wide ring with dwell=15, one full loop
    dwell_b = 4'd15;
    tick(2);
    rst = 1'b0;
    adv_cnt = 0; wrap_cnt = 0;
    for (int i = 1; i <= 96; i++) begin
      tick(1);
      adv_cnt  += int'(adv_b);
      wrap_cnt += int'(wrap_b);
      if (i == 15) check("b_hold15_q", int'(q_b), 'h01);
      if (i == 16) check("b_step16_q", int'(q_b), 'h02);
    end
    check("b_loop_q", int'(q_b), 'h01);
    check("b_loop_adv", adv_cnt, 6);
    check("b_loop_wrap", wrap_cnt, 1);

`ifdef RING_SEQ_ONEHOT_CHECK_EN
    // 6: corrupt the ring and watch it recover
    en = 1'b0;
    tick(1);
    force dut_a.q_q = 4'b0110;
    inj_a = 1'b1;
    #2;
    release dut_a.q_q;
    tick(1);
    inj_a = 1'b0;
    check("err_q", int'(q_a), 'h1);
    check("err_idx", int'(idx_a), 0);
    check("err_pulse", int'(err_a), 1);
    tick(1);
    check("err_clear", int'(err_a), 0);
`endif

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
